// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 16 input vectors of a 4-input function and captures its truth table.
// Define TT_GOLDEN_CHECK_EN to add the golden-table comparison outputs pass_o / fail_idx_o.
`timescale 1ns/1ps
module tt_sweep_ctrl #(
    parameter int unsigned   SETTLE = 2,
    parameter logic [15:0]   GOLDEN = 16'hCFF3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        f_i,
    output logic [3:0]  vec_o,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt_o
`ifdef TT_GOLDEN_CHECK_EN
    ,
    output logic        pass_o,
    output logic [3:0]  fail_idx_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [3:0] idx;
    logic [3:0] settle_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: next state is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_APPLY;
            S_APPLY: begin
                if (abort)            state_d = S_IDLE;
                else if (SETTLE == 0) state_d = S_SAMPLE;
                else                  state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)                          state_d = S_IDLE;
                else if (settle_cnt == SETTLE_LAST) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)             state_d = S_IDLE;
                else if (idx == 4'hF)  state_d = S_DONE;
                else                   state_d = S_APPLY;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: an abort suppresses every update in the cycle it is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 4'h0;
            vec_o      <= 4'h0;
            tt_o       <= 16'h0000;
            settle_cnt <= 4'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx        <= 4'h0;
                        tt_o       <= 16'h0000;
                        settle_cnt <= 4'h0;
                    end
                end
                S_APPLY: begin
                    if (!abort) begin
                        vec_o      <= idx;
                        settle_cnt <= 4'h0;
                    end
                end
                S_SETTLE: begin
                    if (!abort) begin
                        if (settle_cnt == SETTLE_LAST) settle_cnt <= 4'h0;
                        else                           settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (!abort) begin
                        tt_o[idx] <= f_i;
                        if (idx != 4'hF) idx <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done = (state_q == S_DONE);

`ifdef TT_GOLDEN_CHECK_EN
    logic [3:0] first_bad;

    // Descending scan so the lowest mismatching index is the one left standing.
    always_comb begin
        first_bad = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (tt_o[i] != GOLDEN[i]) first_bad = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_o     <= 1'b0;
            fail_idx_o <= 4'h0;
        end else if (state_q == S_IDLE && start) begin
            pass_o     <= 1'b0;
            fail_idx_o <= 4'h0;
        end else if (state_q == S_DONE) begin
            pass_o     <= (tt_o == GOLDEN);
            fail_idx_o <= first_bad;
        end
    end
`else
    logic unused_golden;
    assign unused_golden = ^GOLDEN;
`endif

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 2: wait cycles between driving a vector and sampling f_i (legal 0..15).
REQ-002 Parameter GOLDEN, default 16'hCFF3: expected truth table, bit k = f({a,b,c,d}=k), a MSB.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a sweep.
REQ-006 abort  input  1  terminate a sweep in progress.
REQ-007 f_i  input  1  output of the function under sweep.
REQ-008 vec_o  output  4  registered {a,b,c,d} driven to the function.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse on sweep completion.
REQ-011 tt_o  output  16  captured truth table, bit k = sampled f_i for vector k.

Function
REQ-012 FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE; encoding free.
REQ-013 IDLE: start=1 -> APPLY; idx<=0, tt_o<=16'h0000, settle counter<=0.
REQ-014 APPLY (1 cycle): vec_o<=idx; next SETTLE if SETTLE>0 else SAMPLE.
REQ-015 SETTLE: count SETTLE cycles exactly, then SAMPLE.
REQ-016 SAMPLE (1 cycle): tt_o[idx]<=f_i; idx==15 -> DONE, else idx<=idx+1 -> APPLY.
REQ-017 Per-vector cost SETTLE+2 cycles; start-to-done latency 16*(SETTLE+2)+1 cycles (done asserted in DONE state).
REQ-018 DONE (1 cycle): done=1, busy=0; next IDLE.
REQ-019 busy=1 in APPLY, SETTLE, SAMPLE; 0 in IDLE, DONE.
REQ-020 start while busy=1 or in DONE ignored; no restart, no tt_o clear.
REQ-021 abort=1 in APPLY/SETTLE/SAMPLE -> IDLE next cycle; no done pulse, no capture that cycle, tt_o keeps partial bits, vec_o holds.
REQ-022 abort and start same cycle in IDLE: start wins; abort ignored outside busy states.
REQ-023 idx is 4 bits; wrap from 15 never occurs (DONE taken instead).
REQ-024 tt_o and vec_o hold their values in IDLE and DONE until next accepted start.

Reset
REQ-025 rst=1 asynchronously forces IDLE, idx=0, vec_o=4'h0, tt_o=16'h0000, busy=0, done=0, settle counter=0.
REQ-026 rst mid-sweep discards sweep; no done pulse after deassertion; first accepted start restarts from vector 0.

Configuration
REQ-027 Macro TT_GOLDEN_CHECK_EN defined: adds outputs pass_o (1) and fail_idx_o (4).
REQ-028 With TT_GOLDEN_CHECK_EN: in DONE cycle pass_o<=(tt_o==GOLDEN); fail_idx_o<=lowest k with tt_o[k]!=GOLDEN[k], 4'h0 on pass; both hold until next accepted start, cleared to 0 at start and reset.
REQ-029 Without TT_GOLDEN_CHECK_EN: ports pass_o, fail_idx_o and comparison logic absent; all other behaviour identical.

Verification
REQ-030 f_i driven by reference function of vec_o, SETTLE=2, start pulse -> done exactly 65 cycles after start; tt_o=16'hCFF3; pass_o=1, fail_idx_o=0.
REQ-031 SETTLE=0, f_i=vec_o[0] -> done after 33 cycles; tt_o=16'hAAAA; with check, pass_o=0, fail_idx_o=4'h0 (bit0 GOLDEN=1, tt=0).
REQ-032 start, abort asserted while vec_o=4'h5 in SETTLE -> IDLE next cycle, no done, busy=0, tt_o bits 4..0 captured, bits 15..5 zero.
REQ-033 start re-pulsed every cycle during sweep -> single done pulse at nominal 65 cycles, tt_o unaffected.
REQ-034 rst asserted asynchronously mid-SETTLE -> all outputs zero immediately, no done; new start yields full correct sweep.
REQ-035 f_i stuck at 1 -> tt_o=16'hFFFF; with check, pass_o=0, fail_idx_o=4'h2.
